add_sched: RTL and testbench

ADD_SCHED -- requirements
Module: add_sched

---
 rtl/add_sched.sv | 179 +++++++++++++++++
 tb/tb_add_sched.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/add_sched.sv
// Two-requester add/subtract scheduler: one 4-bit ripple adder is time-shared
// nibble by nibble (LSB first), with round-robin grant of the two requesters.

module add4_ripple (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);
  logic c1, c2, c3;

  assign s_o[0] = a_i[0] ^ b_i[0] ^ c_i;
  assign c1     = (a_i[0] & b_i[0]) | (c_i & (a_i[0] ^ b_i[0]));
  assign s_o[1] = a_i[1] ^ b_i[1] ^ c1;
  assign c2     = (a_i[1] & b_i[1]) | (c1 & (a_i[1] ^ b_i[1]));
  assign s_o[2] = a_i[2] ^ b_i[2] ^ c2;
  assign c3     = (a_i[2] & b_i[2]) | (c2 & (a_i[2] ^ b_i[2]));
  assign s_o[3] = a_i[3] ^ b_i[3] ^ c3;
  assign c_o    = (a_i[3] & b_i[3]) | (c3 & (a_i[3] ^ b_i[3]));
endmodule

// state | meaning
// IDLE  | waiting for a request; grant (ack) is combinational here
// RUN   | one operand nibble per cycle through the shared adder
// DONE  | result strobe (res_valid) for one cycle
module add_sched #(
  parameter int NIB = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0,
  input  logic [4*NIB-1:0]   a0,
  input  logic [4*NIB-1:0]   b0,
  input  logic               sub0,
  output logic               ack0,
  input  logic               req1,
  input  logic [4*NIB-1:0]   a1,
  input  logic [4*NIB-1:0]   b1,
  input  logic               sub1,
  output logic               ack1,
  output logic               busy,
  output logic               res_valid,
  output logic               res_id,
  output logic [4*NIB-1:0]   res,
  output logic               res_cout,
  output logic               res_ovf
);
  localparam int W  = 4 * NIB;
  localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [W-1:0]    res_q, res_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            owner_q, owner_d;
  logic            prio_q, prio_d;
  logic            a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic            cout_q, cout_d, ovf_q, ovf_d, id_q, id_d;

  logic [3:0]      sum;
  logic            sum_co;
  logic            grant0, grant1, sel_sub;
  logic [W-1:0]    sel_b;

  // operands shift right each RUN cycle, so the live nibble is always [3:0]
  add4_ripple u_add (
    .a_i (a_q[3:0]),
    .b_i (b_q[3:0]),
    .c_i (carry_q),
    .s_o (sum),
    .c_o (sum_co)
  );

  // prio_q=1 means requester 1 wins a tie
  assign grant0 = req0 & (~req1 | ~prio_q);
  assign grant1 = req1 & (~req0 |  prio_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    res_d   = res_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    id_d    = id_q;
    ack0    = 1'b0;
    ack1    = 1'b0;
    sel_sub = grant1 ? sub1 : sub0;
    sel_b   = grant1 ? b1 : b0;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          ack0    = grant0;
          ack1    = grant1;
          a_d     = grant1 ? a1 : a0;
          b_d     = sel_sub ? ~sel_b : sel_b;
          carry_d = sel_sub;
          idx_d   = '0;
          acc_d   = '0;
          owner_d = grant1;
          prio_d  = ~grant1;
          a_msb_d = a_d[W-1];
          b_msb_d = b_d[W-1];
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        acc_d   = (acc_q >> 4) | (W'(sum) << (W - 4));
        carry_d = sum_co;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IW'(NIB - 1)) begin
          idx_d   = '0;
          res_d   = acc_d;
          cout_d  = sum_co;
          ovf_d   = (a_msb_q == b_msb_q) & (acc_d[W-1] != a_msb_q);
          id_d    = owner_q;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      id_q    <= id_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign res_valid = (state_q == DONE);
  assign res       = res_q;
  assign res_cout  = cout_q;
  assign res_ovf   = ovf_q;
  assign res_id    = id_q;
endmodule

// File: tb/tb_add_sched.sv
// Bench for add_sched: directed vectors, reset abort, round-robin order and a
// randomized two-requester phase against a cycle-level behavioural model.

module tb_add_sched;
  localparam int NIB = 4;
  localparam int W   = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         req0, req1, sub0, sub1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         ack0, ack1, busy, res_valid, res_id, res_cout, res_ovf;
  logic [W-1:0] res;

  logic         n_req0, n_req1, n_sub0, n_sub1;
  logic [3:0]   n_a0, n_b0, n_a1, n_b1, n_res;
  logic         n_ack0, n_ack1, n_busy, n_valid, n_id, n_cout, n_ovf;

  add_sched #(.NIB(NIB)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .a0(a0), .b0(b0), .sub0(sub0), .ack0(ack0),
    .req1(req1), .a1(a1), .b1(b1), .sub1(sub1), .ack1(ack1),
    .busy(busy), .res_valid(res_valid), .res_id(res_id), .res(res),
    .res_cout(res_cout), .res_ovf(res_ovf)
  );

  add_sched #(.NIB(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req0(n_req0), .a0(n_a0), .b0(n_b0), .sub0(n_sub0), .ack0(n_ack0),
    .req1(n_req1), .a1(n_a1), .b1(n_b1), .sub1(n_sub1), .ack1(n_ack1),
    .busy(n_busy), .res_valid(n_valid), .res_id(n_id), .res(n_res),
    .res_cout(n_cout), .res_ovf(n_ovf)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // model state: cycles of work remaining after a grant, tie owner, results
  int           cnt = 0;
  bit           tie = 1'b0;
  logic [W-1:0] pend_res, hold_res;
  logic         pend_cout, pend_ovf, pend_id, hold_cout, hold_ovf, hold_id;
  bit           acked0, acked1;
  int           cyc = 0;
  int           dut_ack_cyc, dut_valid_cyc;
  bit           valid_seen, dut_ack_seen, dut_ack_id, last_ack0;
  logic [W-1:0] cap_res;
  logic         cap_cout, cap_ovf, cap_id;

  function automatic void ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                                 output logic [W-1:0] r, output logic c, output logic o);
    int sa, sb, t;
    longint ua, ub;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    if (sub) begin
      t = sa - sb;
      c = (ua >= ub);
      r = W'(ua - ub);
    end else begin
      t = sa + sb;
      c = ((ua + ub) >= 65536);
      r = W'(ua + ub);
    end
    o = (t > 32767) || (t < -32768);
  endfunction

  task automatic model_reset();
    cnt = 0; tie = 1'b0;
    hold_res = '0; hold_cout = 1'b0; hold_ovf = 1'b0; hold_id = 1'b0;
    acked0 = 1'b0; acked1 = 1'b0;
  endtask

  // one clock: check at negedge, advance model at posedge, return at posedge+1
  task automatic step();
    bit e0, e1;
    e0 = 1'b0; e1 = 1'b0;
    dut_ack_seen = 1'b0;
    @(negedge clk);
    if (cnt == 0) begin
      if (req0 && req1) begin
        e0 = (tie == 1'b0); e1 = (tie == 1'b1);
      end else begin
        e0 = req0; e1 = req1;
      end
    end
    if (cnt == 1) begin
      hold_res = pend_res; hold_cout = pend_cout; hold_ovf = pend_ovf; hold_id = pend_id;
    end
    check("ack0", ack0, e0);
    check("ack1", ack1, e1);
    check("ack_both", ack0 & ack1, 0);
    check("busy", busy, cnt != 0);
    check("res_valid", res_valid, cnt == 1);
    check("res", res, hold_res);
    check("res_cout", res_cout, hold_cout);
    check("res_ovf", res_ovf, hold_ovf);
    check("res_id", res_id, hold_id);
    last_ack0 = ack0;
    if (ack0 | ack1) begin
      dut_ack_seen = 1'b1; dut_ack_id = ack1; dut_ack_cyc = cyc;
    end
    if (res_valid) begin
      valid_seen = 1'b1; dut_valid_cyc = cyc;
      cap_res = res; cap_cout = res_cout; cap_ovf = res_ovf; cap_id = res_id;
    end
    if (e0) ref_op(a0, b0, sub0, pend_res, pend_cout, pend_ovf);
    if (e1) ref_op(a1, b1, sub1, pend_res, pend_cout, pend_ovf);
    if (e0 | e1) begin
      pend_id = e1;
      tie = e0;
    end
    @(posedge clk);
    cyc++;
    if (cnt > 0) cnt--;
    if (e0 | e1) cnt = NIB + 1;
    acked0 = e0; acked1 = e1;
    #1;
  endtask

  task automatic run_op(input bit side, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input logic [W-1:0] er, input logic ec, input logic eo);
    if (side) begin req1 = 1'b1; a1 = a; b1 = b; sub1 = sub; end
    else      begin req0 = 1'b1; a0 = a; b0 = b; sub0 = sub; end
    valid_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (acked0) req0 = 1'b0;
      if (acked1) req1 = 1'b0;
      if (valid_seen) break;
    end
    check("op_done", valid_seen, 1);
    check("d_res", cap_res, er);
    check("d_cout", cap_cout, ec);
    check("d_ovf", cap_ovf, eo);
    check("d_id", cap_id, side);
    check("d_latency", dut_valid_cyc - dut_ack_cyc, NIB + 1);
  endtask

  task automatic rand_side(input bit s);
    bit r, k;
    r = s ? req1 : req0;
    k = s ? acked1 : acked0;
    if (k) begin
      if ($urandom_range(1, 0) == 0) r = 1'b0;
      else begin
        if (s) begin a1 = W'($urandom); b1 = W'($urandom); sub1 = 1'($urandom); end
        else   begin a0 = W'($urandom); b0 = W'($urandom); sub0 = 1'($urandom); end
      end
    end else if (r) begin
      if ($urandom_range(19, 0) == 0) r = 1'b0;
    end else if ($urandom_range(2, 0) == 0) begin
      r = 1'b1;
      if (s) begin a1 = W'($urandom); b1 = W'($urandom); sub1 = 1'($urandom); end
      else   begin a0 = W'($urandom); b0 = W'($urandom); sub0 = 1'($urandom); end
    end
    if (s) req1 = r; else req0 = r;
  endtask

  initial begin
    int order[$];
    rst_n = 1'b0;
    req0 = 0; req1 = 0; sub0 = 0; sub1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    n_req0 = 0; n_req1 = 0; n_sub0 = 0; n_sub1 = 0; n_a0 = 0; n_b0 = 0; n_a1 = 0; n_b1 = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_res", res, 0);
    check("rst_valid", res_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // both requesters held from reset release: strict alternation
    req0 = 1; a0 = 16'h0001; b0 = 16'h0002;
    req1 = 1; a1 = 16'h0010; b1 = 16'h0003; sub1 = 1;
    for (int i = 0; i < 40 && order.size() < 4; i++) begin
      step();
      if (dut_ack_seen) order.push_back(int'(dut_ack_id));
    end
    check("rr_count", order.size(), 4);
    for (int i = 0; i < order.size(); i++) check("rr_order", order[i], i % 2);
    req0 = 0; req1 = 0;
    repeat (NIB + 2) step();

    run_op(0, 16'h1234, 16'h0FFF, 0, 16'h2233, 0, 0);
    run_op(1, 16'h0005, 16'h0007, 1, 16'hFFFE, 0, 0);
    run_op(1, 16'h0007, 16'h0005, 1, 16'h0002, 1, 0);
    run_op(0, 16'h7FFF, 16'h0001, 0, 16'h8000, 0, 1);
    run_op(0, 16'hFFFF, 16'h0001, 0, 16'h0000, 1, 0);
    run_op(1, 16'h8000, 16'h0001, 1, 16'h7FFF, 1, 1);

    // reset in the second RUN cycle aborts the operation
    req0 = 1; a0 = 16'hABCD; b0 = 16'h1111; sub0 = 0;
    for (int i = 0; i < 10 && cnt != NIB; i++) begin
      step();
      if (acked0) req0 = 0;
    end
    check("abort_reach_run2", cnt, NIB);
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_valid", res_valid, 0);
    check("arst_ack", {ack0, ack1}, 0);
    check("arst_res", res, 0);
    check("arst_flags", {res_cout, res_ovf, res_id}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    repeat (NIB + 3) step();
    req0 = 1; req1 = 1;
    step();
    check("post_rst_grant0", last_ack0, 1);
    req0 = 0; req1 = 0;
    repeat (NIB + 3) step();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step();
      rand_side(0);
      rand_side(1);
    end
    req0 = 0; req1 = 0;
    repeat (NIB + 3) step();

    // NIB=1 instance: result two cycles after ack
    n_req0 = 1; n_a0 = 4'h9; n_b0 = 4'h8; n_sub0 = 0;
    @(negedge clk);
    check("n1_ack", n_ack0, 1);
    @(posedge clk); #1;
    n_req0 = 0;
    @(negedge clk);
    check("n1_run_valid", n_valid, 0);
    @(negedge clk);
    check("n1_valid", n_valid, 1);
    check("n1_res", n_res, 4'h1);
    check("n1_cout", n_cout, 1);
    check("n1_ovf", n_ovf, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
